cpu_bus_arbiter: RTL

Two-requester round-robin arbiter and sequencer in front of cpu_bus. Example pairing: CPU fetch/load-store port as m0, keyboard or DMA engine as m1.
Serialises one transaction at a time onto the shared bus interface (address, wdata, WLEN, EN_N, READY, rdata).
Masks the stale registered READY during a settle window. Enforces a timeout.
Returns a one-cycle ack plus read data to the granted requester.

---
 rtl/cpu_bus_arbiter_if.sv | 52 +++++
 rtl/cpu_bus_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// Requester-side and cpu_bus-side signals of the two-port bus arbiter.
// Latency: none, wires only.
// Backpressure: req is level-held until ack; bus READY stretches the access.
interface cpu_bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [1:0]  m0_wlen;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [1:0]  m1_wlen;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_WLEN;
    logic        bus_EN_N;
    logic        bus_READY;
    logic [31:0] bus_rdata;

    logic [1:0]  grant;
    logic        busy;

    // Arbiter side: serves the requesters and drives the shared bus.
    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wlen,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_addr, m1_wdata, m1_wlen,
        output m1_ack, m1_err, m1_rdata,
        output bus_address, bus_wdata, bus_WLEN, bus_EN_N,
        input  bus_READY, bus_rdata,
        output grant, busy
    );

    // Environment side: requesters plus the bus target.
    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wlen,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_addr, m1_wdata, m1_wlen,
        input  m1_ack, m1_err, m1_rdata,
        input  bus_address, bus_wdata, bus_WLEN, bus_EN_N,
        output bus_READY, bus_rdata,
        input  grant, busy
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Two-requester round-robin arbiter/sequencer serialising accesses onto cpu_bus.
// Latency: grant to ack is SETTLE_CYC+1 cycles minimum, plus bus wait cycles.
// Backpressure: requests wait in IDLE while busy; bus READY (or timeout) ends each access.
module cpu_bus_arbiter #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    cpu_bus_arbiter_if.slave  io
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  wlen_q, wlen_d;
    logic        en_n_q, en_n_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        busy_q, busy_d;
    logic        win;
    logic        owner;

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wlen_d       = wlen_q;
        en_n_d       = en_n_q;
        ack_d        = ack_q;
        err_d        = err_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        win          = 1'b0;
        owner        = grant_q[1];

        unique case (state_q)
            IDLE: begin
                if (io.m0_req || io.m1_req) begin
                    // On a tie the requester that did not win last time goes first.
                    if (io.m0_req && io.m1_req) win = ~last_grant_q;
                    else                        win = io.m1_req;
                    addr_d       = win ? io.m1_addr  : io.m0_addr;
                    wdata_d      = win ? io.m1_wdata : io.m0_wdata;
                    wlen_d       = win ? io.m1_wlen  : io.m0_wlen;
                    en_n_d       = 1'b0;
                    grant_d      = win ? 2'b10 : 2'b01;
                    last_grant_d = win;
                    cnt_d        = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                // READY is still the stale registered value from the previous access.
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT: begin
                if (io.bus_READY) begin
                    if (wlen_q == 2'b00) begin
                        if (owner) rdata1_d = io.bus_rdata;
                        else       rdata0_d = io.bus_rdata;
                    end
                    ack_d[owner] = 1'b1;
                    en_n_d       = 1'b1;
                    state_d      = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    ack_d[owner] = 1'b1;
                    err_d[owner] = 1'b1;
                    en_n_d       = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                // req is not sampled here, which guarantees an EN_N-high gap.
                ack_d   = 2'b00;
                err_d   = 2'b00;
                grant_d = 2'b00;
                wlen_d  = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight access silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wlen_q       <= '0;
            en_n_q       <= 1'b1;
            ack_q        <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wlen_q       <= wlen_d;
            en_n_q       <= en_n_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign io.m0_ack      = ack_q[0];
    assign io.m0_err      = err_q[0];
    assign io.m0_rdata    = rdata0_q;
    assign io.m1_ack      = ack_q[1];
    assign io.m1_err      = err_q[1];
    assign io.m1_rdata    = rdata1_q;
    assign io.bus_address = addr_q;
    assign io.bus_wdata   = wdata_q;
    assign io.bus_WLEN    = wlen_q;
    assign io.bus_EN_N    = en_n_q;
    assign io.grant       = grant_q;
    assign io.busy        = busy_q;
endmodule
